fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/core_pkg.sv | 15 +
 rtl/if_id_register.sv | 42 ++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, default reset PC and
// the fetch FSM state type.
package core_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats stall, stall beats load, and an idle
// cycle with no load inserts a bubble.
module if_id_register
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [24:0] imm_field_d
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (flush || (!stall && !load)) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (!stall) begin
            instr_d    <= instr;
            pc_d       <= pc;
            pc_plus4_d <= pc_plus4;
            valid_d    <= 1'b1;
        end
    end

    assign imm_field_d = instr_d[31:7];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request, a one-entry hold buffer for
// responses that land during a decode stall, and a drain path for redirects.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pcSrc_e,
    input  logic [31:0] pcTarget_e,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcPlus4_d,
    output logic        valid_d,
    output logic [24:0] inmGen_d
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx, pc_plus4;
    logic [31:0]  redirect_pc, redirect_nx;
    logic [31:0]  hold_buf, hold_nx;
    logic [31:0]  target;
    logic         ifid_load;
    logic [31:0]  ifid_instr;

    assign target   = pcTarget_e & 32'hFFFF_FFFC;
    assign pc_plus4 = pc + 32'd4;
    // pc never moves while a request is outstanding, so it is also the
    // pending request address during DRAIN.
    assign imem_addr = pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            redirect_pc <= '0;
            hold_buf    <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            redirect_pc <= redirect_nx;
            hold_buf    <= hold_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        redirect_nx = redirect_pc;
        hold_nx     = hold_buf;
        ifid_load   = 1'b0;
        ifid_instr  = hold_buf;
        imem_req    = 1'b0;
        case (state)
            // Responses seen here belong to a request abandoned by reset.
            IDLE: state_nx = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (pcSrc_e) begin
                    if (imem_rvalid) begin
                        pc_nx = target;
                    end else begin
                        redirect_nx = target;
                        state_nx    = DRAIN;
                    end
                end else if (imem_rvalid && !flush_d) begin
                    if (stall_d) begin
                        hold_nx  = imem_rdata;
                        state_nx = HOLD;
                    end else begin
                        ifid_load  = 1'b1;
                        ifid_instr = imem_rdata;
                        pc_nx      = pc_plus4;
                    end
                end
            end
            HOLD: begin
                if (pcSrc_e) begin
                    pc_nx    = target;
                    state_nx = FETCH;
                end else if (flush_d) begin
                    state_nx = FETCH;
                end else if (!stall_d) begin
                    ifid_load = 1'b1;
                    pc_nx     = pc_plus4;
                    state_nx  = FETCH;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (pcSrc_e) redirect_nx = target;
                if (imem_rvalid) begin
                    pc_nx    = pcSrc_e ? target : redirect_pc;
                    state_nx = FETCH;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    if_id_register u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load),
        .stall      (stall_d),
        .flush      (flush_d),
        .instr      (ifid_instr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pcPlus4_d),
        .valid_d    (valid_d),
        .imm_field_d(inmGen_d)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized memory/pipeline
// environment compared against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_rvalid, stall_d, flush_d, pcSrc_e, valid_d;
    logic [31:0] imem_addr, imem_rdata, pcTarget_e, instr_d, pc_d, pcPlus4_d;
    logic [24:0] inmGen_d;

    logic        w_req, w_rvalid, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;
    logic [31:0] w_rdata = 32'h8765_4321;
    logic [24:0] w_inm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall_d(stall_d),
        .flush_d(flush_d), .pcSrc_e(pcSrc_e), .pcTarget_e(pcTarget_e),
        .instr_d(instr_d), .pc_d(pc_d), .pcPlus4_d(pcPlus4_d),
        .valid_d(valid_d), .inmGen_d(inmGen_d)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .stall_d(1'b0),
        .flush_d(1'b0), .pcSrc_e(1'b0), .pcTarget_e(32'h0),
        .instr_d(w_instr), .pc_d(w_pc), .pcPlus4_d(w_pc4),
        .valid_d(w_valid), .inmGen_d(w_inm)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    // Reference model: "started" is false for the single post-reset cycle,
    // a full hold buffer means the fetcher is parked, "drain" means a
    // redirect is waiting for the outstanding response to be thrown away.
    bit          m_started, m_hold_full, m_drain, e_valid;
    logic [31:0] m_pc, m_hold, m_redir, e_instr, e_pc, e_pc4;

    function automatic bit exp_req();
        return m_started && !m_hold_full;
    endfunction

    task automatic model_reset();
        m_started = 0; m_hold_full = 0; m_drain = 0;
        m_pc = 32'h0; m_hold = 32'h0; m_redir = 32'h0;
        e_instr = NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
    endtask

    task automatic model_step(input bit rv, input logic [31:0] rd, input bit st,
                              input bit fl, input bit ps, input logic [31:0] tgt);
        logic [31:0] t;
        logic [31:0] li, lp;
        bit          ld;
        t = {tgt[31:2], 2'b00};
        ld = 0; li = 0; lp = 0;
        if (!m_started) begin
            m_started = 1;
            return;
        end
        if (m_hold_full) begin
            if (ps) begin m_hold_full = 0; m_pc = t; end
            else if (fl) m_hold_full = 0;
            else if (!st) begin
                ld = 1; li = m_hold; lp = m_pc; m_pc = m_pc + 4; m_hold_full = 0;
            end
        end else if (m_drain) begin
            if (ps) m_redir = t;
            if (rv) begin m_pc = m_redir; m_drain = 0; end
        end else if (ps) begin
            if (rv) m_pc = t;
            else begin m_drain = 1; m_redir = t; end
        end else if (rv && !fl) begin
            if (st) begin m_hold_full = 1; m_hold = rd; end
            else begin ld = 1; li = rd; lp = m_pc; m_pc = m_pc + 4; end
        end
        if (fl || (!st && !ld)) begin
            e_instr = NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
        end else if (!st) begin
            e_instr = li; e_pc = lp; e_pc4 = lp + 4; e_valid = 1;
        end
    endtask

    // Drive one cycle of inputs, compare outputs to the model, then advance.
    task automatic cycle(input bit rv = 0, input logic [31:0] rd = 0, input bit st = 0,
                         input bit fl = 0, input bit ps = 0, input logic [31:0] tgt = 0);
        imem_rvalid = rv; imem_rdata = rd; stall_d = st;
        flush_d = fl; pcSrc_e = ps; pcTarget_e = tgt;
        #1;
        chk("req",     32'(imem_req), 32'(exp_req()));
        chk("addr",    imem_addr, m_pc);
        chk("instr_d", instr_d, e_instr);
        chk("pc_d",    pc_d, e_pc);
        chk("pc4_d",   pcPlus4_d, e_pc4);
        chk("valid_d", 32'(valid_d), 32'(e_valid));
        chk("imm_d",   32'(inmGen_d), e_instr >> 7);
        @(posedge clk);
        model_step(rv, rd, st, fl, ps, tgt);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; imem_rvalid = 0; imem_rdata = 0; stall_d = 0;
        flush_d = 0; pcSrc_e = 0; pcTarget_e = 0; w_rvalid = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_req",   32'(imem_req), 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_instr", instr_d, NOP);
        chk("rst_pc",    pc_d, 32'h0);
        chk("rst_pc4",   pcPlus4_d, 32'h0);
        chk("rst_valid", 32'(valid_d), 32'h0);
        chk("rst_imm",   32'(inmGen_d), 32'h0);
        model_reset();
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit busy;
        int cnt;
        do_reset();
        chk("034_idle_req", 32'(imem_req), 32'h0);
        chk("038_addr0", w_addr, 32'hFFFF_FFFC);
        cycle();
        chk("034_addr0", imem_addr, 32'h0);
        chk("038_req", 32'(w_req), 32'h1);
        cycle();
        w_rvalid = 1;
        cycle(1, 32'h1111_1093);
        w_rvalid = 0;
        chk("034_addr1", imem_addr, 32'h4);
        chk("034_pc_d0", pc_d, 32'h0);
        chk("034_valid", 32'(valid_d), 32'h1);
        chk("038_wrap_addr", w_addr, 32'h0);
        chk("038_pc_d", w_pc, 32'hFFFF_FFFC);
        chk("038_pc4_d", w_pc4, 32'h0);
        chk("038_instr", w_instr, w_rdata);
        chk("038_imm", 32'(w_inm), w_rdata >> 7);
        chk("038_valid", 32'(w_valid), 32'h1);
        cycle();
        cycle(1, 32'h2222_2093);
        chk("034_addr2", imem_addr, 32'h8);
        chk("034_pc_d1", pc_d, 32'h4);
        cycle(0, 0, 0, 0, 1, 32'h100);
        chk("036_drain_req", 32'(imem_req), 32'h1);
        chk("036_drain_addr", imem_addr, 32'h8);
        cycle();
        chk("036_drain_addr2", imem_addr, 32'h8);
        cycle(1, 32'hBAD0_0093);
        chk("036_target", imem_addr, 32'h100);
        chk("036_dropped", 32'(valid_d), 32'h0);
        cycle();
        cycle(1, 32'h0123_4517, 1);
        chk("035_hold_req", 32'(imem_req), 32'h0);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        chk("035_held_valid", 32'(valid_d), 32'h0);
        cycle(0, 0, 0);
        chk("035_instr", instr_d, 32'h0123_4517);
        chk("035_imm", 32'(inmGen_d), 32'h0002_468A);
        chk("035_pc_d", pc_d, 32'h100);
        chk("035_next_addr", imem_addr, 32'h104);
        cycle();
        cycle(1, 32'h3333_3093, 0, 1, 1, 32'h200);
        chk("037_instr", instr_d, NOP);
        chk("037_valid", 32'(valid_d), 32'h0);
        chk("037_addr", imem_addr, 32'h200);
        cycle();
        cycle(1, 32'h4444_4093, 0, 1);
        chk("026_refetch", imem_addr, 32'h200);
        cycle(0, 0, 0, 0, 1, 32'h300);
        cycle(0, 0, 0, 0, 1, 32'h403);
        cycle(1, 32'h5555_5093);
        chk("024_last_wins", imem_addr, 32'h400);
        cycle();
        #2 rst = 1;
        #1;
        chk("039_req", 32'(imem_req), 32'h0);
        chk("039_addr", imem_addr, 32'h0);
        chk("039_instr", instr_d, NOP);
        chk("039_valid", 32'(valid_d), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
        cycle(1, 32'hDEAD_BEEF);
        chk("039_stale_valid", 32'(valid_d), 32'h0);
        chk("039_stale_instr", instr_d, NOP);
        cycle();

        do_reset();
        busy = 0; cnt = 0;
        repeat (3000) begin
            bit rv;
            rv = 0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin rv = 1; busy = 0; end
            end else if (exp_req()) begin
                busy = 1;
                cnt  = $urandom_range(1, 3);
            end
            cycle(rv, $urandom, ($urandom % 5) == 0, ($urandom % 12) == 0,
                  ($urandom % 16) == 0, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
